// File: rtl/islem_denetleyici.sv
// Operation controller for the calculator's arithmetic units: latches operands,
// waits a settle interval, then captures the unit's handshake result or reports an error.
module islem_denetleyici #(
  parameter int YERLESME    = 1,
  parameter int ZAMAN_ASIMI = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        basla,
  input  logic [1:0]  islem,
  input  logic [31:0] giris1,
  input  logic [31:0] giris2,
  output logic [31:0] sayi1,
  output logic [31:0] sayi2,
  output logic [1:0]  islem_sec,
  input  logic [63:0] sonuc,
  input  logic        tasma,
  input  logic        hazir,
  input  logic        gecerli,
  output logic [63:0] cikti,
  output logic [31:0] cikti_tam,
  output logic        cikti_tasma,
  output logic        cikti_gecerli,
  output logic        hata,
  output logic        mesgul
);

  typedef enum logic [2:0] {
    BOSTA = 3'd0,
    YUKLE = 3'd1,
    BEKLE = 3'd2,
    TAMAM = 3'd3,
    HATA  = 3'd4
  } durum_t;

  localparam int SW = (YERLESME > 1) ? $clog2(YERLESME) : 1;
  localparam int TW = (ZAMAN_ASIMI > 1) ? $clog2(ZAMAN_ASIMI) : 1;
  localparam logic [SW-1:0] YER_SON   = SW'(YERLESME - 1);
  localparam logic [TW-1:0] ZAMAN_SON = TW'(ZAMAN_ASIMI - 1);

  durum_t        durum, durum_next;
  logic [SW-1:0] yer_sayac, yer_next;
  logic [TW-1:0] zaman_sayac, zaman_next;
  logic          kabul, yakala;

  // Next-state, counter and strobe decode
  always_comb begin
    durum_next = durum;
    yer_next   = yer_sayac;
    zaman_next = zaman_sayac;
    kabul      = 1'b0;
    yakala     = 1'b0;
    case (durum)
      BOSTA: begin
        if (basla) begin
          if (islem[1] == 1'b0) begin
            kabul      = 1'b1;
            yer_next   = '0;
            durum_next = YUKLE;
          end else begin
            durum_next = HATA;
          end
        end else begin
          durum_next = BOSTA;
        end
      end
      // Handshake is ignored while settling: a combinational unit may still show stale hazir.
      YUKLE: begin
        if (yer_sayac == YER_SON) begin
          zaman_next = '0;
          durum_next = BEKLE;
        end else begin
          yer_next = yer_sayac + 1'b1;
        end
      end
      // Capture takes priority over an expiring timeout in the same cycle.
      BEKLE: begin
        if (hazir && gecerli) begin
          yakala     = 1'b1;
          durum_next = TAMAM;
        end else if (zaman_sayac == ZAMAN_SON) begin
          durum_next = HATA;
        end else begin
          zaman_next = zaman_sayac + 1'b1;
        end
      end
      TAMAM:   durum_next = BOSTA;
      HATA:    durum_next = BOSTA;
      default: durum_next = BOSTA;
    endcase
  end

  // State, counters and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      durum         <= BOSTA;
      yer_sayac     <= '0;
      zaman_sayac   <= '0;
      sayi1         <= 32'd0;
      sayi2         <= 32'd0;
      islem_sec     <= 2'd0;
      cikti         <= 64'd0;
      cikti_tam     <= 32'd0;
      cikti_tasma   <= 1'b0;
      cikti_gecerli <= 1'b0;
      hata          <= 1'b0;
      mesgul        <= 1'b0;
    end else begin
      durum         <= durum_next;
      yer_sayac     <= yer_next;
      zaman_sayac   <= zaman_next;
      cikti_gecerli <= (durum_next == TAMAM);
      hata          <= (durum_next == HATA);
      mesgul        <= (durum_next != BOSTA);
      if (kabul) begin
        sayi1     <= giris1;
        sayi2     <= giris2;
        islem_sec <= islem;
      end
      if (yakala) begin
        cikti       <= sonuc;
        cikti_tam   <= sonuc[47:16];
        cikti_tasma <= tasma;
      end
    end
  end

endmodule

// File: tb/tb_islem_denetleyici.sv
// Directed bench for islem_denetleyici: a vector table for single operations plus
// hand-written sequences for stale handshake, timeout, mid-op reset and back-to-back starts.
module tb_islem_denetleyici;

  logic        clk = 1'b0;
  logic        rst, basla, tasma, hazir, gecerli;
  logic [1:0]  islem, islem_sec;
  logic [31:0] giris1, giris2, sayi1, sayi2, cikti_tam;
  logic [63:0] sonuc, cikti;
  logic        cikti_tasma, cikti_gecerli, hata, mesgul;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  islem_denetleyici #(.YERLESME(1), .ZAMAN_ASIMI(16)) dut (
    .clk(clk), .rst(rst), .basla(basla), .islem(islem),
    .giris1(giris1), .giris2(giris2),
    .sayi1(sayi1), .sayi2(sayi2), .islem_sec(islem_sec),
    .sonuc(sonuc), .tasma(tasma), .hazir(hazir), .gecerli(gecerli),
    .cikti(cikti), .cikti_tam(cikti_tam), .cikti_tasma(cikti_tasma),
    .cikti_gecerli(cikti_gecerli), .hata(hata), .mesgul(mesgul)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [63:0] s;
    logic        tas;
    logic        exp_hata;
    logic [63:0] exp_c;
    logic [31:0] exp_tam;
    logic        exp_tas;
    logic [31:0] exp_s1, exp_s2;
    logic [1:0]  exp_sel;
    int          exp_lat;
  } vec_t;

  vec_t vt [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int k;
    logic seen_valid;

    // exp_lat: clock edges from the accepting edge (counted as 1) to the pulse.
    vt[0] = '{2'b01, 32'd10, 32'd3, 64'h0000_0000_0007_0000, 1'b0, 1'b0,
              64'h0000_0000_0007_0000, 32'd7, 1'b0, 32'd10, 32'd3, 2'b01, 3};
    vt[1] = '{2'b00, 32'd5, 32'd6, 64'h0000_0000_000B_0000, 1'b0, 1'b0,
              64'h0000_0000_000B_0000, 32'd11, 1'b0, 32'd5, 32'd6, 2'b00, 3};
    vt[2] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 64'hDEAD_BEEF_1234_5678, 1'b1, 1'b0,
              64'hDEAD_BEEF_1234_5678, 32'hBEEF_1234, 1'b1, 32'h8000_0000, 32'h8000_0000, 2'b00, 3};
    vt[3] = '{2'b10, 32'd1, 32'd2, 64'h1111_1111_1111_1111, 1'b0, 1'b1,
              64'hDEAD_BEEF_1234_5678, 32'hBEEF_1234, 1'b1, 32'h8000_0000, 32'h8000_0000, 2'b00, 1};
    vt[4] = '{2'b11, 32'd4, 32'd9, 64'h2222_2222_2222_2222, 1'b0, 1'b1,
              64'hDEAD_BEEF_1234_5678, 32'hBEEF_1234, 1'b1, 32'h8000_0000, 32'h8000_0000, 2'b00, 1};
    vt[5] = '{2'b01, 32'hFFFF_FFFF, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0,
              64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 32'd1, 2'b01, 3};

    rst = 1'b1; basla = 1'b0; islem = 2'b00; giris1 = 32'd0; giris2 = 32'd0;
    sonuc = 64'd0; tasma = 1'b0; hazir = 1'b0; gecerli = 1'b0;
    tick(); tick();
    chk("reset_sayi1", 64'(sayi1), 64'd0);
    chk("reset_cikti", cikti, 64'd0);
    chk("reset_flags", 64'({cikti_gecerli, hata, mesgul, cikti_tasma, islem_sec}), 64'd0);
    rst = 1'b0;
    tick();

    // Table-driven single operations with an immediate responder
    for (int i = 0; i < 6; i++) begin
      islem = vt[i].op; giris1 = vt[i].a; giris2 = vt[i].b;
      sonuc = vt[i].s; tasma = vt[i].tas; hazir = 1'b1; gecerli = 1'b1;
      basla = 1'b1;
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
        tick();
        basla = 1'b0;
        if (cikti_gecerli || hata) begin
          lat = c;
          break;
        end
      end
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vt[i].exp_lat));
      chk($sformatf("v%0d_hata", i), 64'(hata), 64'(vt[i].exp_hata));
      chk($sformatf("v%0d_gecerli", i), 64'(cikti_gecerli), 64'(!vt[i].exp_hata));
      chk($sformatf("v%0d_mesgul", i), 64'(mesgul), 64'd1);
      chk($sformatf("v%0d_cikti", i), cikti, vt[i].exp_c);
      chk($sformatf("v%0d_tam", i), 64'(cikti_tam), 64'(vt[i].exp_tam));
      chk($sformatf("v%0d_tasma", i), 64'(cikti_tasma), 64'(vt[i].exp_tas));
      chk($sformatf("v%0d_sayi", i), {sayi1, sayi2}, {vt[i].exp_s1, vt[i].exp_s2});
      chk($sformatf("v%0d_sel", i), 64'(islem_sec), 64'(vt[i].exp_sel));
      tick();
      chk($sformatf("v%0d_after", i), 64'({cikti_gecerli, hata, mesgul}), 64'd0);
    end

    // Stale hazir/gecerli during settle must not be captured
    hazir = 1'b1; gecerli = 1'b1; sonuc = 64'h0000_0000_FFFF_0000; tasma = 1'b0;
    islem = 2'b00; giris1 = 32'd5; giris2 = 32'd6; basla = 1'b1;
    tick();
    basla = 1'b0;
    chk("stale_no_early", 64'(cikti_gecerli), 64'd0);
    tick();
    chk("stale_no_yukle_capture", 64'(cikti_gecerli), 64'd0);
    sonuc = 64'h0000_0000_000B_0000;
    tick();
    chk("stale_pulse", 64'(cikti_gecerli), 64'd1);
    chk("stale_tam", 64'(cikti_tam), 64'd11);
    tick();

    // Timeout: hazir without gecerli
    hazir = 1'b1; gecerli = 1'b0; islem = 2'b00; giris1 = 32'd7; giris2 = 32'd8;
    basla = 1'b1;
    tick();
    basla = 1'b0;
    tick();
    k = -1; seen_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (cikti_gecerli) seen_valid = 1'b1;
      if (hata) begin
        k = c;
        break;
      end
    end
    chk("timeout_cycles", 64'(k), 64'd16);
    chk("timeout_no_valid", 64'(seen_valid), 64'd0);
    chk("timeout_keeps_tam", 64'(cikti_tam), 64'd11);
    chk("timeout_mesgul", 64'(mesgul), 64'd1);
    tick();
    chk("timeout_idle", 64'({hata, mesgul}), 64'd0);

    // Reset two cycles into BEKLE aborts silently
    basla = 1'b1; islem = 2'b01; giris1 = 32'd20; giris2 = 32'd4;
    tick();
    basla = 1'b0;
    tick(); tick(); tick();
    chk("pre_reset_busy", 64'(mesgul), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_sayi", {sayi1, sayi2}, 64'd0);
    chk("rst_cikti", cikti, 64'd0);
    chk("rst_flags", 64'({cikti_gecerli, hata, mesgul, cikti_tasma, islem_sec, cikti_tam}), 64'd0);
    gecerli = 1'b1; sonuc = 64'h0000_0000_0003_0000;
    tick(); tick();
    chk("rst_no_pulse", 64'({cikti_gecerli, hata, mesgul}), 64'd0);
    basla = 1'b1; islem = 2'b01; giris1 = 32'd9; giris2 = 32'd6;
    tick();
    basla = 1'b0;
    chk("rst_new_accept", 64'(sayi1), 64'd9);
    tick(); tick();
    chk("rst_new_pulse", 64'(cikti_gecerli), 64'd1);
    chk("rst_new_tam", 64'(cikti_tam), 64'd3);
    tick();

    // basla held high: accept every 4th edge, ignored while busy
    basla = 1'b1; islem = 2'b01; giris2 = 32'd200; hazir = 1'b1; gecerli = 1'b1;
    for (int t = 0; t < 12; t++) begin
      giris1 = 32'(100 + t);
      tick();
      chk($sformatf("b2b_sayi1_t%0d", t), 64'(sayi1), 64'(100 + (t / 4) * 4));
      chk($sformatf("b2b_valid_t%0d", t), 64'(cikti_gecerli), 64'((t % 4) == 2));
      chk($sformatf("b2b_mesgul_t%0d", t), 64'(mesgul), 64'((t % 4) != 3));
    end
    basla = 1'b0;
    tick(); tick(); tick(); tick();
    chk("final_idle", 64'({mesgul, hata}), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
